// File: rtl/ixc_assign_elastic.sv
// ixc_assign_elastic: WIDTH-bit elastic buffer moving R to L with valid/ready
// handshakes on both sides, optional zero-latency bypass when empty, a
// synchronous flush, and occupancy / sticky-peak reporting.
module ixc_assign_elastic #(
    parameter int unsigned  WIDTH  = 32,
    parameter int unsigned  DEPTH  = 2,
    parameter bit           BYPASS = 1'b0,
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] R,
    input  logic             R_VLD,
    output logic             R_RDY,
    output logic [WIDTH-1:0] L,
    output logic             L_VLD,
    input  logic             L_RDY,
    input  logic             FLUSH,
    output logic [CW-1:0]    COUNT,
    output logic [CW-1:0]    PEAK
);

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    peak_q,  peak_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    logic             not_empty;
    logic             bypass_take;
    logic             push;
    logic             pop;

    // Handshake outputs, bypass decision and next-state for pointers/occupancy/peak
    always_comb begin
        not_empty   = (count_q != '0);
        R_RDY       = ~RST & ~FLUSH & (count_q < FULL_CNT);
        L_VLD       = ~RST & ~FLUSH & (not_empty | (BYPASS & R_VLD));
        if (RST) begin
            L = '0;
        end else if (not_empty) begin
            L = mem_q[rd_ptr_q];
        end else if (BYPASS && R_VLD) begin
            L = R;
        end else begin
            L = '0;
        end

        // An empty buffer hands the word straight to the sink; it is never stored
        bypass_take = BYPASS & ~not_empty & R_VLD & L_RDY & ~FLUSH;
        push        = R_VLD & R_RDY & ~bypass_take;
        pop         = L_VLD & L_RDY & not_empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        peak_d   = peak_q;

        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            peak_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            peak_d  = (count_d > peak_q) ? count_d : peak_q;
        end

        COUNT = count_q;
        PEAK  = peak_q;
    end

    // Control state: pointers, occupancy and sticky peak
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            peak_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            peak_q   <= peak_d;
        end
    end

    // Word storage; contents are don't-care until written, so no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= R;
        end
    end

endmodule

// File: tb/tb_ixc_assign_elastic.sv
// Scoreboard bench for ixc_assign_elastic: three instances (DEPTH=2 registered,
// DEPTH=3 registered, DEPTH=2 bypass). Stimulus pushes expected words into a
// per-instance queue; monitors pop and compare on every L_VLD & L_RDY.
module tb_ixc_assign_elastic;

    logic clk;
    logic rst;

    // DEPTH=2, BYPASS=0
    logic [31:0] a_r, a_l;
    logic        a_rv, a_rr, a_lv, a_lr, a_fl;
    logic [1:0]  a_cnt, a_pk;
    // DEPTH=3, BYPASS=0
    logic [31:0] b_r, b_l;
    logic        b_rv, b_rr, b_lv, b_lr, b_fl;
    logic [1:0]  b_cnt, b_pk;
    // DEPTH=2, BYPASS=1
    logic [31:0] c_r, c_l;
    logic        c_rv, c_rr, c_lv, c_lr, c_fl;
    logic [1:0]  c_cnt, c_pk;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];

    int n_checks = 0;
    int n_errors = 0;

    ixc_assign_elastic #(.WIDTH(32), .DEPTH(2), .BYPASS(1'b0)) u_a (
        .CLK(clk), .RST(rst), .R(a_r), .R_VLD(a_rv), .R_RDY(a_rr), .L(a_l),
        .L_VLD(a_lv), .L_RDY(a_lr), .FLUSH(a_fl), .COUNT(a_cnt), .PEAK(a_pk));

    ixc_assign_elastic #(.WIDTH(32), .DEPTH(3), .BYPASS(1'b0)) u_b (
        .CLK(clk), .RST(rst), .R(b_r), .R_VLD(b_rv), .R_RDY(b_rr), .L(b_l),
        .L_VLD(b_lv), .L_RDY(b_lr), .FLUSH(b_fl), .COUNT(b_cnt), .PEAK(b_pk));

    ixc_assign_elastic #(.WIDTH(32), .DEPTH(2), .BYPASS(1'b1)) u_c (
        .CLK(clk), .RST(rst), .R(c_r), .R_VLD(c_rv), .R_RDY(c_rr), .L(c_l),
        .L_VLD(c_lv), .L_RDY(c_lr), .FLUSH(c_fl), .COUNT(c_cnt), .PEAK(c_pk));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every accepted output word is compared against the queue head
    always @(negedge clk) begin
        if (a_lv === 1'b1 && a_lr === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_word", a_l, 32'hxxxx_xxxx);
            else chk("a_word", a_l, qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_lv === 1'b1 && b_lr === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_word", b_l, 32'hxxxx_xxxx);
            else chk("b_word", b_l, qb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (c_lv === 1'b1 && c_lr === 1'b1) begin
            if (qc.size() == 0) chk("c_unexpected_word", c_l, 32'hxxxx_xxxx);
            else chk("c_word", c_l, qc.pop_front());
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        a_r = '0; a_rv = 0; a_lr = 0; a_fl = 0;
        b_r = '0; b_rv = 0; b_lr = 0; b_fl = 0;
        c_r = '0; c_rv = 0; c_lr = 0; c_fl = 0;

        // Reset state
        @(negedge clk);
        chk("rst_r_rdy", 32'(a_rr), 32'd0);
        chk("rst_l_vld", 32'(a_lv), 32'd0);
        chk("rst_l", a_l, 32'd0);
        chk("rst_count", 32'(a_cnt), 32'd0);
        chk("rst_peak", 32'(a_pk), 32'd0);
        drive_edge();
        rst = 1'b0;

        // T1: registered path, 1-cycle latency
        drive_edge();
        a_r = 32'hDEAD_BEEF; a_rv = 1; a_lr = 1; qa.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_r_rdy", 32'(a_rr), 32'd1);
        chk("t1_l_vld_same_cycle", 32'(a_lv), 32'd0);
        drive_edge();
        a_rv = 0; a_r = '0;
        @(negedge clk);
        chk("t1_l_vld_next", 32'(a_lv), 32'd1);
        chk("t1_count1", 32'(a_cnt), 32'd1);
        drive_edge();
        @(negedge clk);
        chk("t1_count0", 32'(a_cnt), 32'd0);
        chk("t1_l_vld_after", 32'(a_lv), 32'd0);
        chk("t1_peak", 32'(a_pk), 32'd1);

        // T2: bypass, same-cycle delivery, nothing stored
        drive_edge();
        c_r = 32'h0000_00A5; c_rv = 1; c_lr = 1; qc.push_back(32'h0000_00A5);
        @(negedge clk);
        chk("t2_l_vld", 32'(c_lv), 32'd1);
        chk("t2_count", 32'(c_cnt), 32'd0);
        drive_edge();
        c_rv = 0; c_r = '0;
        @(negedge clk);
        chk("t2_count_after", 32'(c_cnt), 32'd0);
        chk("t2_l_vld_after", 32'(c_lv), 32'd0);
        chk("t2_peak", 32'(c_pk), 32'd0);

        // T3: DEPTH=3 fill with stalled sink, then drain with wrap
        for (int i = 1; i <= 3; i++) begin
            drive_edge();
            b_r = 32'(i); b_rv = 1; b_lr = 0; qb.push_back(32'(i));
            @(negedge clk);
            chk("t3_r_rdy_fill", 32'(b_rr), 32'd1);
        end
        drive_edge();
        b_r = 32'h4; qb.push_back(32'h4);
        @(negedge clk);
        chk("t3_r_rdy_full", 32'(b_rr), 32'd0);
        chk("t3_count_full", 32'(b_cnt), 32'd3);
        chk("t3_peak_full", 32'(b_pk), 32'd3);
        chk("t3_l_hold", b_l, 32'h1);
        drive_edge();
        b_lr = 1;
        @(negedge clk);
        chk("t3_r_rdy_full_pop", 32'(b_rr), 32'd0);
        drive_edge();
        @(negedge clk);
        chk("t3_r_rdy_reopen", 32'(b_rr), 32'd1);
        chk("t3_count_2", 32'(b_cnt), 32'd2);
        drive_edge();
        b_rv = 0; b_r = '0;
        @(negedge clk);
        chk("t3_count_pushpop", 32'(b_cnt), 32'd2);
        drive_edge();
        @(negedge clk);
        chk("t3_count_1", 32'(b_cnt), 32'd1);
        drive_edge();
        @(negedge clk);
        chk("t3_count_0", 32'(b_cnt), 32'd0);
        chk("t3_peak_sticky", 32'(b_pk), 32'd3);

        // T4: steady push+pop at COUNT=1
        drive_edge();
        a_r = 32'h100; a_rv = 1; a_lr = 0; qa.push_back(32'h100);
        for (int i = 1; i <= 8; i++) begin
            drive_edge();
            a_r = 32'h100 + 32'(i); a_rv = 1; a_lr = 1; qa.push_back(32'h100 + 32'(i));
            @(negedge clk);
            chk("t4_count", 32'(a_cnt), 32'd1);
        end
        drive_edge();
        a_rv = 0; a_r = '0;
        drive_edge();
        @(negedge clk);
        chk("t4_count_drained", 32'(a_cnt), 32'd0);
        chk("t4_peak", 32'(a_pk), 32'd1);
        chk("t4_queue_empty", 32'(qa.size()), 32'd0);

        // T5: flush a full buffer
        a_lr = 0;
        for (int i = 0; i < 2; i++) begin
            a_r = (i == 0) ? 32'h11 : 32'h22; a_rv = 1;
            drive_edge();
        end
        a_rv = 0; a_r = '0;
        @(negedge clk);
        chk("t5_count_full", 32'(a_cnt), 32'd2);
        chk("t5_peak_full", 32'(a_pk), 32'd2);
        drive_edge();
        a_fl = 1; a_lr = 1;
        @(negedge clk);
        chk("t5_flush_l_vld", 32'(a_lv), 32'd0);
        chk("t5_flush_r_rdy", 32'(a_rr), 32'd0);
        drive_edge();
        a_fl = 0;
        @(negedge clk);
        chk("t5_count_after", 32'(a_cnt), 32'd0);
        chk("t5_peak_after", 32'(a_pk), 32'd0);
        chk("t5_l_vld_after", 32'(a_lv), 32'd0);
        drive_edge();
        a_r = 32'h55; a_rv = 1; qa.push_back(32'h55);
        drive_edge();
        a_rv = 0; a_r = '0;
        drive_edge();
        @(negedge clk);
        chk("t5_queue_empty", 32'(qa.size()), 32'd0);

        // T6: asynchronous reset mid-stream with two words buffered
        a_lr = 0;
        a_r = 32'h66; a_rv = 1; qa.push_back(32'h66);
        drive_edge();
        a_r = 32'h77; qa.push_back(32'h77);
        drive_edge();
        a_rv = 0; a_r = '0;
        @(negedge clk);
        chk("t6_count_pre", 32'(a_cnt), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_l_vld", 32'(a_lv), 32'd0);
        chk("t6_rst_l", a_l, 32'd0);
        chk("t6_rst_count", 32'(a_cnt), 32'd0);
        chk("t6_rst_r_rdy", 32'(a_rr), 32'd0);
        qa.delete();
        drive_edge();
        rst = 1'b0;
        a_lr = 1;
        @(negedge clk);
        chk("t6_no_stale", 32'(a_lv), 32'd0);
        drive_edge();
        a_r = 32'h99; a_rv = 1; qa.push_back(32'h99);
        drive_edge();
        a_rv = 0; a_r = '0;
        drive_edge();
        @(negedge clk);

        chk("end_qa_empty", 32'(qa.size()), 32'd0);
        chk("end_qb_empty", 32'(qb.size()), 32'd0);
        chk("end_qc_empty", 32'(qc.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
